// File: rtl/jtag_tap_emulator_if.sv
// jtag_tap_emulator_if
// Serial JTAG pins, per-channel USER data returns and the TAP status
// decodes that pass between a JTAG driver (master) and the TAP
// emulator (slave).
interface jtag_tap_emulator_if #(
  parameter int IR_LENGTH = 10,
  parameter int NUM_USER  = 4
);
  logic                 tms;
  logic                 tdi;
  logic                 tdo;
  logic [NUM_USER-1:0]  user_tdo;
  logic                 test_logic_reset;
  logic                 run_test_idle;
  logic                 capture_dr;
  logic                 shift_dr;
  logic                 update_dr;
  logic [NUM_USER-1:0]  user_sel;
  logic                 ir_is_user;
  logic [IR_LENGTH-1:0] ir_value;

  modport master (
    output tms, tdi, user_tdo,
    input  tdo, test_logic_reset, run_test_idle, capture_dr, shift_dr,
    input  update_dr, user_sel, ir_is_user, ir_value
  );

  modport slave (
    input  tms, tdi, user_tdo,
    output tdo, test_logic_reset, run_test_idle, capture_dr, shift_dr,
    output update_dr, user_sel, ir_is_user, ir_value
  );
endinterface

// File: rtl/jtag_tap_emulator.sv
// jtag_tap_emulator
// IEEE 1149.1 TAP controller emulating a two-device chain (ARM DAP +
// 7-series FPGA) as one long IR. USER instructions hand the DR path to
// external user logic; every other instruction uses the internal BYPASS
// register.
// Optional feature: define JTAG_TAP_IDCODE_EN to add a 32-bit IDCODE DR.
// With it, the reset instruction is IDCODE_IR; without it, the reset
// instruction is all-ones and IDCODE_IR falls through to BYPASS.
module jtag_tap_emulator #(
  parameter int                            IR_LENGTH    = 10,
  parameter int                            NUM_USER     = 4,
  parameter logic [NUM_USER*IR_LENGTH-1:0] USER_IR      = {10'b0001_100011, 10'b0001_100010,
                                                           10'b0001_000011, 10'b0001_000010},
  parameter logic [IR_LENGTH-1:0]          IDCODE_IR    = 10'b0001_001001,
  parameter logic [31:0]                   IDCODE_VALUE = 32'h0362_D093
) (
  input logic                 tck,
  input logic                 rst_n,
  jtag_tap_emulator_if.slave  bus
);

  typedef enum logic [3:0] {
    S_TLR       = 4'd0,
    S_RTI       = 4'd1,
    S_SEL_DR    = 4'd2,
    S_CAP_DR    = 4'd3,
    S_SHIFT_DR  = 4'd4,
    S_EXIT1_DR  = 4'd5,
    S_PAUSE_DR  = 4'd6,
    S_EXIT2_DR  = 4'd7,
    S_UPDATE_DR = 4'd8,
    S_SEL_IR    = 4'd9,
    S_CAP_IR    = 4'd10,
    S_SHIFT_IR  = 4'd11,
    S_EXIT1_IR  = 4'd12,
    S_PAUSE_IR  = 4'd13,
    S_EXIT2_IR  = 4'd14,
    S_UPDATE_IR = 4'd15
  } tap_state_t;

  // Fixed IR capture pattern: bit0=1, bit1=0, all others 0.
  localparam logic [IR_LENGTH-1:0] LP_IR_CAPTURE = {{(IR_LENGTH-1){1'b0}}, 1'b1};

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_LENGTH-1:0] LP_RST_IR = IDCODE_IR;
`else
  localparam logic [IR_LENGTH-1:0] LP_RST_IR = {IR_LENGTH{1'b1}};
`endif

  // Standard 1149.1 tms-driven state transition.
  function automatic tap_state_t f_next_state(input tap_state_t s, input logic tms);
    tap_state_t n;
    case (s)
      S_TLR:       n = tms ? S_TLR       : S_RTI;
      S_RTI:       n = tms ? S_SEL_DR    : S_RTI;
      S_SEL_DR:    n = tms ? S_SEL_IR    : S_CAP_DR;
      S_CAP_DR:    n = tms ? S_EXIT1_DR  : S_SHIFT_DR;
      S_SHIFT_DR:  n = tms ? S_EXIT1_DR  : S_SHIFT_DR;
      S_EXIT1_DR:  n = tms ? S_UPDATE_DR : S_PAUSE_DR;
      S_PAUSE_DR:  n = tms ? S_EXIT2_DR  : S_PAUSE_DR;
      S_EXIT2_DR:  n = tms ? S_UPDATE_DR : S_SHIFT_DR;
      S_UPDATE_DR: n = tms ? S_SEL_DR    : S_RTI;
      S_SEL_IR:    n = tms ? S_TLR       : S_CAP_IR;
      S_CAP_IR:    n = tms ? S_EXIT1_IR  : S_SHIFT_IR;
      S_SHIFT_IR:  n = tms ? S_EXIT1_IR  : S_SHIFT_IR;
      S_EXIT1_IR:  n = tms ? S_UPDATE_IR : S_PAUSE_IR;
      S_PAUSE_IR:  n = tms ? S_EXIT2_IR  : S_PAUSE_IR;
      S_EXIT2_IR:  n = tms ? S_UPDATE_IR : S_SHIFT_IR;
      S_UPDATE_IR: n = tms ? S_SEL_DR    : S_RTI;
      default:     n = S_TLR;
    endcase
    return n;
  endfunction

  // One-hot USER channel decode; scanning from the top down lets the
  // lowest matching slice win when codes are duplicated.
  function automatic logic [NUM_USER-1:0] f_user_decode(input logic [IR_LENGTH-1:0] ir);
    logic [NUM_USER-1:0] sel;
    sel = '0;
    for (int k = NUM_USER - 1; k >= 0; k--) begin
      if (ir == IR_LENGTH'(USER_IR >> (k * IR_LENGTH))) begin
        sel = NUM_USER'(1) << k;
      end
    end
    return sel;
  endfunction

  tap_state_t           r_state;
  tap_state_t           w_next_state;
  logic [IR_LENGTH-1:0] r_ir_shift;
  logic [IR_LENGTH-1:0] r_ir_value;
  logic                 r_bypass;
  logic [NUM_USER-1:0]  w_user_sel;
  logic                 w_ir_is_user;
  logic                 w_dr_bit0;
  logic                 w_tdo;

  assign w_next_state = f_next_state(r_state, bus.tms);
  assign w_user_sel   = f_user_decode(r_ir_value);
  assign w_ir_is_user = |w_user_sel;

  // TAP state register; reset forces TEST_LOGIC_RESET without a clock.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_TLR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // IR shift path and the latched instruction; any entry into
  // TEST_LOGIC_RESET reloads the reset instruction.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_ir_shift <= '0;
      r_ir_value <= LP_RST_IR;
    end else begin
      case (r_state)
        S_CAP_IR:   r_ir_shift <= LP_IR_CAPTURE;
        S_SHIFT_IR: r_ir_shift <= {bus.tdi, r_ir_shift[IR_LENGTH-1:1]};
        default:    r_ir_shift <= r_ir_shift;
      endcase
      if (w_next_state == S_TLR) begin
        r_ir_value <= LP_RST_IR;
      end else if (r_state == S_UPDATE_IR) begin
        r_ir_value <= r_ir_shift;
      end else begin
        r_ir_value <= r_ir_value;
      end
    end
  end

  // One-bit BYPASS register: cleared on capture, follows tdi while shifting.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_bypass <= 1'b0;
    end else begin
      case (r_state)
        S_CAP_DR:   r_bypass <= 1'b0;
        S_SHIFT_DR: r_bypass <= bus.tdi;
        default:    r_bypass <= r_bypass;
      endcase
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] r_idcode;
  logic        w_idcode_sel;

  assign w_idcode_sel = (r_ir_value == IDCODE_IR) && !w_ir_is_user;
  assign w_dr_bit0    = w_idcode_sel ? r_idcode[0] : r_bypass;

  // IDCODE DR: loads the device ID on capture and shifts out LSB first.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_idcode <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_CAP_DR:   r_idcode <= w_idcode_sel ? IDCODE_VALUE : r_idcode;
        S_SHIFT_DR: r_idcode <= w_idcode_sel ? {bus.tdi, r_idcode[31:1]} : r_idcode;
        default:    r_idcode <= r_idcode;
      endcase
    end
  end
`else
  assign w_dr_bit0 = r_bypass;
`endif

  // tdo mux: IR bit0, selected USER line or internal DR bit0; idle low.
  always_comb begin
    w_tdo = 1'b0;
    case (r_state)
      S_SHIFT_IR: w_tdo = r_ir_shift[0];
      S_SHIFT_DR: begin
        if (w_ir_is_user) begin
          w_tdo = |(w_user_sel & bus.user_tdo);
        end else begin
          w_tdo = w_dr_bit0;
        end
      end
      default:    w_tdo = 1'b0;
    endcase
  end

  assign bus.tdo              = w_tdo;
  assign bus.test_logic_reset = (r_state == S_TLR);
  assign bus.run_test_idle    = (r_state == S_RTI);
  assign bus.capture_dr       = (r_state == S_CAP_DR)    && w_ir_is_user;
  assign bus.shift_dr         = (r_state == S_SHIFT_DR)  && w_ir_is_user;
  assign bus.update_dr        = (r_state == S_UPDATE_DR) && w_ir_is_user;
  assign bus.user_sel         = w_user_sel;
  assign bus.ir_is_user       = w_ir_is_user;
  assign bus.ir_value         = r_ir_value;

endmodule

// File: tb/tb_jtag_tap_emulator.sv
// tb_jtag_tap_emulator
// Directed JTAG scans; the stimulus pushes expected values into a
// scoreboard queue and a monitor compares them on the falling tck edge.
module tb_jtag_tap_emulator;

  localparam int K_TDO  = 0;
  localparam int K_TLR  = 1;
  localparam int K_RTI  = 2;
  localparam int K_CAP  = 3;
  localparam int K_SH   = 4;
  localparam int K_UPD  = 5;
  localparam int K_USEL = 6;
  localparam int K_ISU  = 7;
  localparam int K_IRV  = 8;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [31:0] RST_IR = 32'h0000_0049;
`else
  localparam logic [31:0] RST_IR = 32'h0000_03FF;
`endif

  logic tck = 1'b0;
  logic rst_n = 1'b1;

  jtag_tap_emulator_if #(.IR_LENGTH(10), .NUM_USER(4)) ifc ();

  jtag_tap_emulator dut (
    .tck   (tck),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 tck = ~tck;

  int          n_total = 0;
  int          n_bad   = 0;
  int          q_kind[$];
  logic [31:0] q_exp[$];
  string       q_name[$];

  task automatic chk(input int kind, input logic [31:0] exp, input string name);
    q_kind.push_back(kind);
    q_exp.push_back(exp);
    q_name.push_back(name);
  endtask

  task automatic drive(input logic tms_v, input logic tdi_v);
    ifc.tms = tms_v;
    ifc.tdi = tdi_v;
  endtask

  task automatic adv();
    @(posedge tck);
    #1;
  endtask

  // Monitor: on every falling edge, compare all pending expectations.
  initial begin
    int          kind;
    logic [31:0] exp;
    logic [31:0] act;
    string       name;
    forever begin
      @(negedge tck);
      while (q_kind.size() > 0) begin
        kind = q_kind.pop_front();
        exp  = q_exp.pop_front();
        name = q_name.pop_front();
        case (kind)
          K_TDO:   act = {31'd0, ifc.tdo};
          K_TLR:   act = {31'd0, ifc.test_logic_reset};
          K_RTI:   act = {31'd0, ifc.run_test_idle};
          K_CAP:   act = {31'd0, ifc.capture_dr};
          K_SH:    act = {31'd0, ifc.shift_dr};
          K_UPD:   act = {31'd0, ifc.update_dr};
          K_USEL:  act = {28'd0, ifc.user_sel};
          K_ISU:   act = {31'd0, ifc.ir_is_user};
          K_IRV:   act = {22'd0, ifc.ir_value};
          default: act = 32'hDEAD_BEEF;
        endcase
        n_total++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
      end
    end
  end

  // IR scan from RUN_TEST_IDLE back to RUN_TEST_IDLE.
  task automatic ir_scan(input logic [9:0] v);
    drive(1'b1, 1'b0); chk(K_RTI, 32'd1, "ir_entry_rti"); adv();
    drive(1'b1, 1'b0); adv();
    drive(1'b0, 1'b0); adv();
    drive(1'b0, 1'b0); chk(K_TDO, 32'd0, "tdo_cap_ir"); adv();
    for (int i = 0; i < 10; i++) begin
      drive(i == 9, v[i]);
      chk(K_TDO, (i == 0) ? 32'd1 : 32'd0, "ir_capture_tdo");
      adv();
    end
    drive(1'b1, 1'b0); adv();
    drive(1'b0, 1'b0); chk(K_TDO, 32'd0, "tdo_update_ir"); adv();
  endtask

  // DR scan of n bits from RUN_TEST_IDLE back to RUN_TEST_IDLE.
  task automatic dr_scan(input int n, input logic [31:0] tdi_v, input int ch,
                         input logic [31:0] ud, input logic [31:0] exp_tdo,
                         input logic is_user);
    drive(1'b1, 1'b0); chk(K_RTI, 32'd1, "dr_entry_rti"); adv();
    drive(1'b0, 1'b0); chk(K_CAP, 32'd0, "cap_in_sel_dr"); adv();
    drive(1'b0, 1'b0); chk(K_CAP, {31'd0, is_user}, "capture_dr");
    chk(K_SH, 32'd0, "shift_in_cap"); adv();
    for (int i = 0; i < n; i++) begin
      drive(i == n - 1, tdi_v[i]);
      for (int j = 0; j < 4; j++) ifc.user_tdo[j] = (j == ch) ? ud[i] : ~ud[i];
      chk(K_TDO, {31'd0, exp_tdo[i]}, "dr_tdo");
      chk(K_SH, {31'd0, is_user}, "shift_dr");
      adv();
    end
    drive(1'b1, 1'b0); chk(K_SH, 32'd0, "shift_in_exit1");
    chk(K_TDO, 32'd0, "tdo_exit1_dr"); adv();
    drive(1'b0, 1'b0); chk(K_UPD, {31'd0, is_user}, "update_dr"); adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.tms = 1'b1;
    ifc.tdi = 1'b0;
    ifc.user_tdo = 4'b0000;
    #1 rst_n = 1'b0;
    adv();
    // Held in reset.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0);
      chk(K_TLR, 32'd1, "rst_tlr");   chk(K_USEL, 32'd0, "rst_user_sel");
      chk(K_TDO, 32'd0, "rst_tdo");   chk(K_IRV, RST_IR, "rst_ir_value");
      chk(K_SH, 32'd0, "rst_shift_dr"); chk(K_RTI, 32'd0, "rst_rti");
      adv();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0); chk(K_TLR, 32'd1, "tms5_tlr"); adv();
    end
    drive(1'b1, 1'b0); chk(K_IRV, RST_IR, "tlr_ir_value"); chk(K_USEL, 32'd0, "tlr_user_sel"); adv();
    drive(1'b0, 1'b0); adv();

`ifdef JTAG_TAP_IDCODE_EN
    dr_scan(32, 32'h0000_0000, 3, 32'h0000_0000, 32'h0362_D093, 1'b0);
`endif

    // USER4 select and 16-bit user scan.
    ir_scan(10'h063);
    drive(1'b0, 1'b0); chk(K_USEL, 32'h8, "user4_sel"); chk(K_ISU, 32'd1, "user4_is_user");
    chk(K_IRV, 32'h063, "user4_ir_value"); adv();
    dr_scan(16, 32'h0000_0000, 3, 32'h0000_A5C3, 32'h0000_A5C3, 1'b1);

    // USER1 select and 4-bit user scan on channel 0.
    ir_scan(10'h042);
    drive(1'b0, 1'b0); chk(K_USEL, 32'h1, "user1_sel"); adv();
    dr_scan(4, 32'h0000_0000, 0, 32'h0000_0006, 32'h0000_0006, 1'b1);

    // BYPASS via all-ones instruction.
    ir_scan(10'h3FF);
    drive(1'b0, 1'b0); chk(K_USEL, 32'd0, "bypass_user_sel"); chk(K_ISU, 32'd0, "bypass_is_user"); adv();
    dr_scan(8, 32'h0000_00B2, 3, 32'h0000_00FF, 32'h0000_0064, 1'b0);

`ifndef JTAG_TAP_IDCODE_EN
    // IDCODE instruction falls through to BYPASS.
    ir_scan(10'h049);
    dr_scan(8, 32'h0000_00FF, 3, 32'h0000_0000, 32'h0000_00FE, 1'b0);
`endif

    // Five tms=1 from SHIFT_IR return to TEST_LOGIC_RESET.
    ir_scan(10'h063);
    drive(1'b1, 1'b0); adv();
    drive(1'b1, 1'b0); adv();
    drive(1'b0, 1'b0); adv();
    drive(1'b0, 1'b0); adv();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1); adv();
    end
    drive(1'b0, 1'b0); chk(K_TLR, 32'd1, "tms5_from_shift_ir");
    chk(K_IRV, RST_IR, "tms5_ir_value"); chk(K_USEL, 32'd0, "tms5_user_sel"); adv();

    // Reset asserted in the middle of a USER DR shift.
    ir_scan(10'h063);
    drive(1'b1, 1'b0); adv();
    drive(1'b0, 1'b0); adv();
    drive(1'b0, 1'b0); adv();
    drive(1'b0, 1'b1); chk(K_SH, 32'd1, "pre_rst_shift_dr"); adv();
    drive(1'b0, 1'b1);
    rst_n = 1'b0;
    chk(K_TLR, 32'd1, "midrst_tlr");  chk(K_SH, 32'd0, "midrst_shift_dr");
    chk(K_USEL, 32'd0, "midrst_user_sel"); chk(K_TDO, 32'd0, "midrst_tdo");
    chk(K_IRV, RST_IR, "midrst_ir_value");
    adv();
    rst_n = 1'b1;
    drive(1'b0, 1'b0); chk(K_TLR, 32'd1, "post_rst_tlr"); adv();
`ifndef JTAG_TAP_IDCODE_EN
    dr_scan(4, 32'h0000_000D, 3, 32'h0000_0000, 32'h0000_000A, 1'b0);
`endif

    drive(1'b1, 1'b0); adv();
    adv();
    n_total++;
    if (q_kind.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", q_kind.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap_emulator.md
JTAG_TAP_EMULATOR -- requirements
Module: jtag_tap_emulator

Interface
REQ-001 SHALL have parameter IR_LENGTH, default 10, meaning total chain IR bits (ARM DAP 4 + 7-series 6).
REQ-002 SHALL have parameter NUM_USER, default 4, legal range 1..4, meaning number of USER channels.
REQ-003 SHALL have parameter USER_IR, NUM_USER*IR_LENGTH bits packed, default {0001_100011, 0001_100010, 0001_000011, 0001_000010}; slice k holds the USER(k+1) code.
REQ-004 SHALL have parameter IDCODE_IR, IR_LENGTH bits, default 0001_001001, meaning the IDCODE instruction.
REQ-005 SHALL have parameter IDCODE_VALUE, 32 bits, default 32'h0362_D093, meaning the IDCODE register content.
REQ-006 tck  input  1  sole clock, all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 tms  input  1  TAP mode select, sampled on rising tck.
REQ-009 tdi  input  1  serial data in, sampled on rising tck.
REQ-010 tdo  output  1  serial data out, combinational mux.
REQ-011 user_tdo  input  NUM_USER  per-channel DR serial out from user logic.
REQ-012 test_logic_reset, run_test_idle, capture_dr, shift_dr, update_dr  output  1 each  state decodes.
REQ-013 user_sel  output  NUM_USER  one-hot active USER channel, all-zero when none.
REQ-014 ir_is_user  output  1  OR-reduction of user_sel.
REQ-015 ir_value  output  IR_LENGTH  currently latched instruction.

Function
REQ-016 SHALL implement the 16-state IEEE 1149.1 TAP FSM (TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR/IR_SCAN, CAPTURE/SHIFT/EXIT1/PAUSE/EXIT2/UPDATE for DR and IR), with standard tms transitions on rising tck.
REQ-017 Five consecutive tms=1 cycles SHALL reach TEST_LOGIC_RESET from any state.
REQ-018 State decode outputs SHALL be combinational from the state register, asserted exactly while the FSM is in that state.
REQ-019 capture_dr, shift_dr, update_dr SHALL be gated by ir_is_user; they stay 0 for non-USER instructions.
REQ-020 CAPTURE_IR SHALL load the IR shift register with pattern ...0001 (bit0=1, bit1=0, rest 0).
REQ-021 SHIFT_IR SHALL shift right: tdi enters bit IR_LENGTH-1; tdo = shift bit0.
REQ-022 UPDATE_IR SHALL copy the shift register into ir_value on the rising edge leaving UPDATE_IR; user_sel is valid from the next cycle.
REQ-023 user_sel[k] SHALL be 1 iff ir_value equals USER_IR slice k; if slices duplicate, lowest k wins.
REQ-024 Non-USER, non-IDCODE instructions SHALL select a 1-bit BYPASS register: 0 in CAPTURE_DR, tdi in SHIFT_DR.
REQ-025 In SHIFT_DR, tdo SHALL be user_tdo[k] when user_sel[k]=1, otherwise the selected internal DR bit0.
REQ-026 Outside SHIFT_IR/SHIFT_DR, tdo SHALL be 0.
REQ-027 Entering TEST_LOGIC_RESET SHALL set ir_value to all-ones (BYPASS) or IDCODE_IR per REQ-032/033.
REQ-028 PAUSE_DR/PAUSE_IR SHALL hold all shift registers unchanged for any number of cycles.

Reset
REQ-029 rst_n=0 SHALL force state TEST_LOGIC_RESET, asynchronously, with no dependency on tck.
REQ-030 During reset: test_logic_reset=1, all other decodes 0, user_sel=0, tdo=0, ir_value per REQ-027.
REQ-031 Deassertion mid-sequence SHALL restart from TEST_LOGIC_RESET; no partial IR survives.

Configuration
REQ-032 With JTAG_TAP_IDCODE_EN defined: a 32-bit IDCODE DR loads IDCODE_VALUE in CAPTURE_DR when ir_value==IDCODE_IR and shifts LSB first; the reset instruction is IDCODE_IR.
REQ-033 Without JTAG_TAP_IDCODE_EN: no IDCODE register; IDCODE_IR behaves as BYPASS; the reset instruction is all-ones.

Verification
REQ-034 rst_n pulse, then tms=1 x5 -> test_logic_reset=1, user_sel=0, ir_value=all-ones (macro off).
REQ-035 Shift IR 0001_100011 LSB first, then UPDATE_IR -> user_sel=4'b1000, ir_is_user=1 the next cycle; first 2 bits on tdo are 1,0.
REQ-036 With USER4 selected, 16-cycle SHIFT_DR with user_tdo[3] driven 16'hA5C3 -> tdo reproduces 16'hA5C3; shift_dr high exactly 16 cycles.
REQ-037 Shift IR 10'h3FF, then 8-bit DR scan with tdi=8'b1011_0010 -> tdo = 0 then tdi delayed one cycle; capture_dr never asserted.
REQ-038 Macro on: after reset, 32-bit DR scan -> tdo = 32'h0362_D093 LSB first.
REQ-039 Pull rst_n low during SHIFT_DR -> state TEST_LOGIC_RESET immediately, shift_dr=0, user_sel=0.
